// File: rtl/counter_scrub_ctrl.sv
// Scrub controller for a Hamming(12,8)-protected counter register: pauses counting,
// checks the stored codeword, writes back single-bit corrections and latches on uncorrectable words.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | counter stopped, waiting for run_req or scrub_now
// ST_RUN     | counter enabled, scrub timer advancing
// ST_CHECK   | counter paused one cycle, codeword and syndrome captured
// ST_CORRECT | one-cycle write-back of the corrected codeword
// ST_FATAL   | uncorrectable syndrome seen, held until clear_fatal
module counter_scrub_ctrl #(
   parameter int unsigned SCRUB_PERIOD = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run_req,
   input  logic        scrub_now,
   input  logic        clear_fatal,
   input  logic [11:0] codeword_in,
   output logic        cnt_enable,
   output logic        wr_en,
   output logic [11:0] wr_data,
   output logic        err_pulse,
   output logic        fatal,
   output logic [7:0]  corr_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_CHECK,
      ST_CORRECT,
      ST_FATAL
   } state_t;

   localparam logic [7:0] TIMER_LAST = 8'(SCRUB_PERIOD - 1);

   state_t      state, state_nxt;
   logic [7:0]  timer, timer_nxt;
   logic [11:0] cap_word;
   logic [3:0]  cap_syn;
   logic [3:0]  syn_in;

   // Syndrome bit i collects every codeword position whose 1-based index has bit i set.
   always_comb begin
      syn_in = '0;
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < 4; i++) begin
            if (((k + 1) & (1 << i)) != 0) begin
               syn_in[i] = syn_in[i] ^ codeword_in[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         timer      <= '0;
         cap_word   <= '0;
         cap_syn    <= '0;
         corr_count <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         if (state == ST_CHECK) begin
            cap_word <= codeword_in;
            cap_syn  <= syn_in;
         end
         // Counted on entry to CORRECT so the new value is visible alongside the write-back.
         if (state == ST_CHECK && state_nxt == ST_CORRECT && corr_count != 8'hFF) begin
            corr_count <= corr_count + 8'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      case (state)
         ST_IDLE: begin
            if (scrub_now) begin
               state_nxt = ST_CHECK;
               timer_nxt = '0;
            end else if (run_req) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (timer == TIMER_LAST || scrub_now) begin
               state_nxt = ST_CHECK;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 8'd1;
               if (!run_req) begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_CHECK: begin
            if (syn_in == 4'd0) begin
               state_nxt = run_req ? ST_RUN : ST_IDLE;
            end else if (syn_in <= 4'd12) begin
               state_nxt = ST_CORRECT;
            end else begin
               state_nxt = ST_FATAL;
            end
         end
         ST_CORRECT: state_nxt = run_req ? ST_RUN : ST_IDLE;
         ST_FATAL: begin
            if (clear_fatal) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_enable = (state == ST_RUN);
      wr_en      = (state == ST_CORRECT);
      err_pulse  = (state == ST_CORRECT);
      fatal      = (state == ST_FATAL);
      wr_data    = '0;
      if (state == ST_CORRECT) begin
         for (int k = 0; k < 12; k++) begin
            wr_data[k] = cap_word[k] ^ (cap_syn == 4'(k + 1));
         end
      end
   end

endmodule

// File: tb/tb_counter_scrub_ctrl.sv
// Bench for counter_scrub_ctrl: directed scrub scenarios, checked every cycle against
// a behavioural model plus hand-computed codeword/syndrome values.
module tb_counter_scrub_ctrl;

   localparam int P = 16;
   localparam int M_IDLE = 0, M_RUN = 1, M_CHECK = 2, M_CORRECT = 3, M_FATAL = 4;
   localparam logic [11:0] GOOD = 12'h2E4;  // encoding of 8'h2D

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run_req = 1'b0;
   logic        scrub_now = 1'b0;
   logic        clear_fatal = 1'b0;
   logic [11:0] codeword_in = GOOD;
   logic        cnt_enable, wr_en, err_pulse, fatal;
   logic [11:0] wr_data;
   logic [7:0]  corr_count;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   counter_scrub_ctrl #(.SCRUB_PERIOD(P)) dut (
      .clk(clk), .reset(reset), .run_req(run_req), .scrub_now(scrub_now),
      .clear_fatal(clear_fatal), .codeword_in(codeword_in), .cnt_enable(cnt_enable),
      .wr_en(wr_en), .wr_data(wr_data), .err_pulse(err_pulse), .fatal(fatal),
      .corr_count(corr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Syndrome as the XOR of the 1-based indices of all set bits.
   function automatic int hsyn(input logic [11:0] w);
      int s = 0;
      for (int k = 0; k < 12; k++) if (w[k]) s = s ^ (k + 1);
      return s;
   endfunction

   function automatic logic [11:0] encode(input logic [7:0] d);
      int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
      logic [11:0] w = '0;
      int s;
      for (int j = 0; j < 8; j++) w[dpos[j] - 1] = d[j];
      s = hsyn(w);
      for (int i = 0; i < 4; i++) if (((s >> i) & 1) != 0) w[(1 << i) - 1] = 1'b1;
      return w;
   endfunction

   // Behavioural model
   int          m_mode = M_IDLE;
   int          m_timer = 0;
   int          m_cnt = 0;
   int          m_syn = 0;
   logic [11:0] m_cw = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_mode = M_IDLE; m_timer = 0; m_cnt = 0; m_syn = 0; m_cw = '0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (scrub_now) begin m_mode = M_CHECK; m_timer = 0; end
               else if (run_req) m_mode = M_RUN;
            end
            M_RUN: begin
               if (m_timer == P - 1 || scrub_now) begin
                  m_mode = M_CHECK; m_timer = 0;
               end else begin
                  m_timer = m_timer + 1;
                  if (!run_req) m_mode = M_IDLE;
               end
            end
            M_CHECK: begin
               m_cw = codeword_in;
               m_syn = hsyn(codeword_in);
               if (m_syn == 0) m_mode = run_req ? M_RUN : M_IDLE;
               else if (m_syn <= 12) begin
                  m_mode = M_CORRECT;
                  if (m_cnt < 255) m_cnt = m_cnt + 1;
               end else m_mode = M_FATAL;
            end
            M_CORRECT: m_mode = run_req ? M_RUN : M_IDLE;
            default: if (clear_fatal) m_mode = M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [11:0] e_wd;
         e_wd = (m_mode == M_CORRECT) ? (m_cw ^ (12'(1) << (m_syn - 1))) : 12'h000;
         chk("cnt_enable", 32'(cnt_enable), 32'(m_mode == M_RUN));
         chk("wr_en", 32'(wr_en), 32'(m_mode == M_CORRECT));
         chk("err_pulse", 32'(err_pulse), 32'(m_mode == M_CORRECT));
         chk("fatal", 32'(fatal), 32'(m_mode == M_FATAL));
         chk("wr_data", 32'(wr_data), 32'(e_wd));
         chk("corr_count", 32'(corr_count), 32'(m_cnt));
      end
   end

   // scrub_now plus a bad word; returns one tick into the cycle after CHECK.
   task automatic inject(input logic [11:0] bad_w, input logic [11:0] good_w);
      @(posedge clk); #1 scrub_now = 1'b1; codeword_in = bad_w;
      @(posedge clk); #1 scrub_now = 1'b0;
      @(posedge clk); #1 codeword_in = good_w;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, w;
      chk("enc_2D", 32'(encode(8'h2D)), 32'h2E4);
      chk("syn_pos6", hsyn(12'h2C4), 6);
      chk("syn_14", hsyn(12'hAE6), 14);

      @(posedge clk); #1 chk_en = 1'b1;
      @(negedge clk);
      chk("rst_cnt_en", 32'(cnt_enable), 0);
      chk("rst_corr", 32'(corr_count), 0);

      // Clean run: 16 enabled cycles, then one CHECK cycle
      @(posedge clk); #1 reset = 1'b0; run_req = 1'b1;
      @(negedge clk);
      w = 0;
      while (!cnt_enable && w < 8) begin @(negedge clk); w++; end
      n = 0;
      while (cnt_enable && n < 40) begin n++; @(negedge clk); end
      chk("run_len", n, 16);
      chk("check_no_wr", 32'(wr_en), 0);

      // Single data-bit error at position 6
      inject(12'h2C4, GOOD);
      @(negedge clk);
      chk("corr6_wr_en", 32'(wr_en), 1);
      chk("corr6_data", 32'(wr_data), 32'h2E4);
      chk("corr6_err", 32'(err_pulse), 1);
      chk("corr6_cnt", 32'(corr_count), 1);

      // Parity-bit error at position 4
      inject(12'h2EC, GOOD);
      @(negedge clk);
      chk("corr4_data", 32'(wr_data), 32'h2E4);
      chk("corr4_cnt", 32'(corr_count), 2);

      // Uncorrectable (syndrome 14); run_req and scrub_now ignored in FATAL
      inject(12'hAE6, GOOD);
      @(negedge clk);
      chk("fatal_set", 32'(fatal), 1);
      chk("fatal_cnt_en", 32'(cnt_enable), 0);
      @(posedge clk); #1 scrub_now = 1'b1;
      @(posedge clk); #1 scrub_now = 1'b0;
      repeat (3) @(posedge clk);
      #1 clear_fatal = 1'b1;
      @(posedge clk); #1 clear_fatal = 1'b0;
      @(negedge clk);
      chk("cleared_fatal", 32'(fatal), 0);
      chk("cleared_idle", 32'(cnt_enable), 0);
      @(negedge clk);
      chk("after_clear_run", 32'(cnt_enable), 1);
      chk("fatal_keeps_cnt", 32'(corr_count), 2);

      // run_req dropped in CHECK, scrub_now during CORRECT not queued
      @(posedge clk); #1 scrub_now = 1'b1; codeword_in = 12'h2C4;
      @(posedge clk); #1 scrub_now = 1'b0; run_req = 1'b0;
      @(posedge clk); #1 codeword_in = GOOD; scrub_now = 1'b1;
      @(negedge clk);
      chk("drop_wr_en", 32'(wr_en), 1);
      @(posedge clk); #1 scrub_now = 1'b0;
      @(negedge clk);
      chk("drop_idle", 32'(cnt_enable), 0);
      chk("drop_no_wr", 32'(wr_en), 0);
      repeat (2) @(posedge clk);

      // Reset during CORRECT aborts write-back
      #1;
      inject(12'h2C4, GOOD);
      reset = 1'b1;
      @(negedge clk);
      chk("pre_rst_wr", 32'(wr_en), 1);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_corr_wr", 32'(wr_en), 0);
      chk("rst_corr_data", 32'(wr_data), 0);
      chk("rst_corr_cnt", 32'(corr_count), 0);

      // Saturation over 260 corrections across every position
      run_req = 1'b1;
      for (int i = 0; i < 260; i++) inject(GOOD ^ (12'(1) << (i % 12)), GOOD);
      @(negedge clk);
      chk("sat_cnt", 32'(corr_count), 255);

      // Reset out of FATAL
      inject(12'hAE6, GOOD);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_fatal", 32'(fatal), 0);
      chk("rst_fatal_cnt", 32'(corr_count), 0);

      // Timer holds while idle between runs
      repeat (10) @(posedge clk);
      #1 run_req = 1'b0;
      repeat (4) @(posedge clk);
      #1 run_req = 1'b1;
      repeat (40) @(posedge clk);
      #1 run_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_scrub_ctrl.md
COUNTER_SCRUB_CTRL -- requirements
Module: counter_scrub_ctrl

Interface
REQ-001 SHALL have parameter SCRUB_PERIOD, default 16, RUN cycles between automatic checks (legal 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port run_req  input  1  user request to count (level).
REQ-005 SHALL have port scrub_now  input  1  one-cycle request for an immediate check.
REQ-006 SHALL have port clear_fatal  input  1  exits FATAL.
REQ-007 SHALL have port codeword_in  input  12  Hamming(12,8) word from the protected counter register, bit k = position k+1.
REQ-008 SHALL have port cnt_enable  output  1  count enable to the protected counter.
REQ-009 SHALL have port wr_en  output  1  one-cycle write-back strobe to the counter register.
REQ-010 SHALL have port wr_data  output  12  corrected codeword, valid when wr_en=1.
REQ-011 SHALL have port err_pulse  output  1  one-cycle flag: single-bit error corrected.
REQ-012 SHALL have port fatal  output  1  uncorrectable syndrome seen; level.
REQ-013 SHALL have port corr_count  output  8  number of corrections, saturating.

Function
REQ-014 SHALL implement states IDLE, RUN, CHECK, CORRECT, FATAL, one-hot or encoded.
REQ-015 Parity positions 1,2,4,8; data positions 3,5,6,7,9,10,11,12; syndrome bit i SHALL be XOR of codeword positions with bit i set in their index.
REQ-016 IDLE: cnt_enable=0; run_req=1 -> RUN next cycle; scrub_now=1 -> CHECK (takes priority over run_req).
REQ-017 RUN: cnt_enable=1; scrub timer increments each RUN cycle; timer reaching SCRUB_PERIOD-1 or scrub_now=1 -> CHECK; else run_req=0 -> IDLE.
REQ-018 Timer SHALL clear on entry to CHECK and hold in all non-RUN states.
REQ-019 CHECK (exactly 1 cycle): cnt_enable=0; capture codeword_in and its syndrome into registers.
REQ-020 After CHECK: syndrome 0 -> RUN if run_req=1 else IDLE; syndrome 1..12 -> CORRECT; syndrome 13..15 -> FATAL.
REQ-021 CORRECT (exactly 1 cycle): wr_en=1, wr_data = captured word with position <syndrome> inverted, err_pulse=1, corr_count+1 saturating at 255; next RUN if run_req=1 else IDLE.
REQ-022 Error detection-to-write-back latency SHALL be 2 cycles from CHECK entry (CHECK, CORRECT); the counter SHALL not advance in either cycle.
REQ-023 FATAL: cnt_enable=0, fatal=1, wr_en=0; ignores run_req and scrub_now; clear_fatal=1 -> IDLE next cycle (fatal low that cycle); corr_count preserved.
REQ-024 run_req falling during CHECK/CORRECT SHALL not abort the sequence; exit goes to IDLE.
REQ-025 scrub_now during CHECK/CORRECT SHALL be ignored (not queued).
REQ-026 wr_data SHALL be 0 whenever wr_en=0; wr_en and err_pulse never asserted outside CORRECT.
REQ-027 All outputs SHALL be registered or decoded purely from registered state.

Reset
REQ-028 reset=1 SHALL take priority over all inputs: state IDLE, timer 0, corr_count 0, captured word/syndrome 0.
REQ-029 During and after reset cycle: cnt_enable=0, wr_en=0, wr_data=0, err_pulse=0, fatal=0; reset in any state including FATAL or CORRECT aborts it with no write-back.

Verification
REQ-030 Clean run: reset, run_req=1, SCRUB_PERIOD=16, valid codewords -> cnt_enable high 16 cycles, low 1 (CHECK), no wr_en, corr_count=0.
REQ-031 Single error: codeword_in = valid encoding of 8'h2D with position 6 flipped at CHECK -> next cycle wr_en=1, wr_data = valid encoding of 8'h2D, err_pulse=1, corr_count=1.
REQ-032 Parity-bit error: position 4 flipped -> wr_data restores position 4 only, corr_count increments.
REQ-033 Uncorrectable: codeword_in giving syndrome 14 at CHECK -> FATAL, fatal=1, cnt_enable=0 with run_req=1; clear_fatal -> IDLE, then RUN.
REQ-034 Saturation/abort: 256 injected single errors -> corr_count holds 255; run_req dropped during CHECK -> CORRECT completes then IDLE; reset during CORRECT -> no wr_en next cycle.
